// File: rtl/multi_zone_lights_ctrl.sv
// rtl/multi_zone_lights_ctrl.sv - per-zone lighting controller with shared hysteresis daylight sensing
//
// Purpose:
//   Drives ZONES lamp enables from per-zone presence sensors and one shared
//   ambient-light sensor. A registered "dark" flag is derived from the
//   daylight level with a hysteresis band above the programmable threshold.
//   Each zone runs an OFF/ON/HOLD state machine with an occupancy hold timer
//   and a 2-bit mode select (auto / force off / force on / occupancy-only).
//
// Ports:
//   clk        in   1                 system clock, rising edge
//   reset      in   1                 asynchronous active-high reset
//   daylight   in   LIGHT_W           ambient light level, unsigned
//   threshold  in   LIGHT_W           dark threshold, unsigned
//   presence   in   ZONES             per-zone motion sensor
//   mode       in   2*ZONES           per-zone mode, [2z+1:2z]
//                                     00 auto, 01 force off, 10 force on,
//                                     11 occupancy-only
//   lights     out  ZONES             registered per-zone lamp enable
//   changed    out  ZONES             one-cycle pulse when lights[z] toggles
//   dark       out  1                 registered hysteresis daylight flag
//   on_count   out  $clog2(ZONES+1)   registered number of lit zones

module multi_zone_lights_ctrl #(
    parameter int ZONES       = 4,
    parameter int LIGHT_W     = 8,
    parameter int HYST        = 16,
    parameter int HOLD_CYCLES = 5,
    parameter int HOLD_W      = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LIGHT_W-1:0]           daylight,
    input  logic [LIGHT_W-1:0]           threshold,
    input  logic [ZONES-1:0]             presence,
    input  logic [2*ZONES-1:0]           mode,
    output logic [ZONES-1:0]             lights,
    output logic [ZONES-1:0]             changed,
    output logic                         dark,
    output logic [$clog2(ZONES+1)-1:0]   on_count
);

    localparam int CNT_W = $clog2(ZONES + 1);

    localparam logic [1:0] MODE_AUTO = 2'b00;
    localparam logic [1:0] MODE_OFF  = 2'b01;
    localparam logic [1:0] MODE_ON   = 2'b10;
    localparam logic [1:0] MODE_OCC  = 2'b11;

    // Largest representable light level, held one bit wider for the
    // saturating threshold+HYST comparison.
    localparam logic [LIGHT_W:0] LIGHT_MAX = {1'b0, {LIGHT_W{1'b1}}};

    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_ON   = 2'b01,
        ST_HOLD = 2'b10
    } zone_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    zone_state_t          state_q [ZONES];
    zone_state_t          state_d [ZONES];
    logic [HOLD_W-1:0]    timer_q [ZONES];
    logic [HOLD_W-1:0]    timer_d [ZONES];

    logic                 dark_q;
    logic                 dark_d;
    logic [ZONES-1:0]     lights_q;
    logic [ZONES-1:0]     lights_d;
    logic [ZONES-1:0]     changed_q;
    logic [ZONES-1:0]     changed_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;

    // ------------------------------------------------------------------
    // Daylight hysteresis
    // ------------------------------------------------------------------
    logic [LIGHT_W:0]     thr_sum;
    logic [LIGHT_W-1:0]   thr_hi;

    // The upper (bright) threshold saturates at full scale so a threshold
    // near the top of the range can still be cleared by a maximal reading.
    assign thr_sum = {1'b0, threshold} + (LIGHT_W + 1)'(HYST);
    assign thr_hi  = (thr_sum > LIGHT_MAX) ? LIGHT_MAX[LIGHT_W-1:0]
                                           : thr_sum[LIGHT_W-1:0];

    always_comb begin
        dark_d = dark_q;
        if (daylight < threshold) begin
            dark_d = 1'b1;
        end else if (daylight >= thr_hi) begin
            dark_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Zone state machines
    // ------------------------------------------------------------------
    // Zone decisions look at dark_q (the flag registered on the previous
    // edge), so a daylight drop reaches the lamps one edge after the flag.
    always_comb begin
        logic [1:0] zmode;
        logic       eff_dark;
        for (int z = 0; z < ZONES; z++) begin
            zmode      = mode[2*z +: 2];
            eff_dark   = (zmode == MODE_OCC) ? 1'b1 : dark_q;
            state_d[z] = state_q[z];
            timer_d[z] = timer_q[z];

            if (zmode == MODE_OFF) begin
                state_d[z] = ST_OFF;
                timer_d[z] = '0;
            end else if (zmode == MODE_ON) begin
                state_d[z] = ST_ON;
                timer_d[z] = '0;
            end else begin
                // Auto and occupancy-only share one machine; only the
                // darkness qualifier for turning on differs.
                case (state_q[z])
                    ST_OFF: begin
                        if (presence[z] && eff_dark) begin
                            state_d[z] = ST_ON;
                        end
                    end
                    ST_ON: begin
                        // Rising daylight deliberately ignored here so an
                        // occupied room never flickers off.
                        if (!presence[z]) begin
                            state_d[z] = ST_HOLD;
                            timer_d[z] = HOLD_RELOAD;
                        end
                    end
                    ST_HOLD: begin
                        if (presence[z]) begin
                            state_d[z] = ST_ON;
                        end else if (timer_q[z] == '0) begin
                            state_d[z] = ST_OFF;
                        end else begin
                            timer_d[z] = timer_q[z] - HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_d[z] = ST_OFF;
                        timer_d[z] = '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output next-state: lamp enables, toggle pulses, lit-zone count
    // ------------------------------------------------------------------
    always_comb begin
        count_d = '0;
        for (int z = 0; z < ZONES; z++) begin
            lights_d[z] = (state_d[z] != ST_OFF);
            count_d     = count_d + CNT_W'(lights_d[z]);
        end
        changed_d = lights_d ^ lights_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int z = 0; z < ZONES; z++) begin
                state_q[z] <= ST_OFF;
                timer_q[z] <= '0;
            end
            dark_q    <= 1'b0;
            lights_q  <= '0;
            changed_q <= '0;
            count_q   <= '0;
        end else begin
            for (int z = 0; z < ZONES; z++) begin
                state_q[z] <= state_d[z];
                timer_q[z] <= timer_d[z];
            end
            dark_q    <= dark_d;
            lights_q  <= lights_d;
            changed_q <= changed_d;
            count_q   <= count_d;
        end
    end

    assign lights   = lights_q;
    assign changed  = changed_q;
    assign dark     = dark_q;
    assign on_count = count_q;

endmodule

// File: tb/tb_multi_zone_lights_ctrl.sv
// tb/tb_multi_zone_lights_ctrl.sv - self-checking bench for multi_zone_lights_ctrl
module tb_multi_zone_lights_ctrl;

    localparam int ZONES   = 4;
    localparam int LIGHT_W = 8;
    localparam int HYST    = 16;
    localparam int HOLD    = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [LIGHT_W-1:0]   daylight;
    logic [LIGHT_W-1:0]   threshold;
    logic [ZONES-1:0]     presence;
    logic [2*ZONES-1:0]   mode;
    logic [ZONES-1:0]     lights;
    logic [ZONES-1:0]     changed;
    logic                 dark;
    logic [2:0]           on_count;

    int errors = 0;
    int checks = 0;

    multi_zone_lights_ctrl #(
        .ZONES(ZONES), .LIGHT_W(LIGHT_W), .HYST(HYST), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .daylight(daylight), .threshold(threshold),
        .presence(presence), .mode(mode), .lights(lights), .changed(changed),
        .dark(dark), .on_count(on_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dl;
        logic [7:0] thr;
        logic [3:0] pres;
        logic [7:0] md;
        logic [3:0] e_lights;
        logic [3:0] e_changed;
        logic       e_dark;
        int         e_count;
    } vec_t;

    vec_t vecs [10];

    // Reference model: lamp lit flag, hold flag and edges spent in hold.
    bit       m_dark;
    bit       m_lit  [ZONES];
    bit       m_hold [ZONES];
    int       m_age  [ZONES];
    bit [3:0] m_changed;
    int       m_count;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_dark = 0;
        m_changed = 0;
        m_count = 0;
        for (int z = 0; z < ZONES; z++) begin
            m_lit[z] = 0; m_hold[z] = 0; m_age[z] = 0;
        end
    endtask

    task automatic model_edge();
        int hi;
        bit prev;
        bit lit_now;
        hi = int'(threshold) + HYST;
        if (hi > 255) hi = 255;
        m_count = 0;
        for (int z = 0; z < ZONES; z++) begin
            int md;
            md = int'(mode[2*z +: 2]);
            prev = m_lit[z];
            if (md == 1) begin
                m_lit[z] = 0; m_hold[z] = 0;
            end else if (md == 2) begin
                m_lit[z] = 1; m_hold[z] = 0;
            end else if (!m_lit[z]) begin
                if (presence[z] && (md == 3 || m_dark)) m_lit[z] = 1;
            end else if (!m_hold[z]) begin
                if (!presence[z]) begin m_hold[z] = 1; m_age[z] = 0; end
            end else if (presence[z]) begin
                m_hold[z] = 0;
            end else begin
                m_age[z]++;
                if (m_age[z] >= HOLD) begin m_lit[z] = 0; m_hold[z] = 0; end
            end
            lit_now = m_lit[z];
            m_changed[z] = lit_now ^ prev;
            m_count += int'(lit_now);
        end
        if (int'(daylight) < int'(threshold)) m_dark = 1;
        else if (int'(daylight) >= hi) m_dark = 0;
    endtask

    function automatic logic [3:0] model_lights();
        logic [3:0] v;
        for (int z = 0; z < ZONES; z++) v[z] = m_lit[z];
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int dl;
        reset = 1'b1; daylight = 8'd150; threshold = 8'd100; presence = '0; mode = '0;

        vecs[0] = '{8'd150, 8'd100, 4'b0001, 8'h00, 4'b0000, 4'b0000, 1'b0, 0};
        vecs[1] = '{8'd90,  8'd100, 4'b0001, 8'h00, 4'b0000, 4'b0000, 1'b1, 0};
        vecs[2] = '{8'd90,  8'd100, 4'b0001, 8'h00, 4'b0001, 4'b0001, 1'b1, 1};
        vecs[3] = '{8'd90,  8'd100, 4'b0001, 8'h00, 4'b0001, 4'b0000, 1'b1, 1};
        vecs[4] = '{8'd110, 8'd100, 4'b0001, 8'h00, 4'b0001, 4'b0000, 1'b1, 1};
        vecs[5] = '{8'd115, 8'd100, 4'b0001, 8'h00, 4'b0001, 4'b0000, 1'b1, 1};
        vecs[6] = '{8'd116, 8'd100, 4'b0001, 8'h00, 4'b0001, 4'b0000, 1'b0, 1};
        vecs[7] = '{8'd99,  8'd100, 4'b0001, 8'h00, 4'b0001, 4'b0000, 1'b1, 1};
        vecs[8] = '{8'd200, 8'd100, 4'b1101, 8'hD8, 4'b1011, 4'b1010, 1'b0, 3};
        vecs[9] = '{8'd200, 8'd100, 4'b1101, 8'hD8, 4'b1011, 4'b0000, 1'b0, 3};

        #2;
        chk("reset_lights", int'(lights), 0);
        chk("reset_changed", int'(changed), 0);
        chk("reset_dark", int'(dark), 0);
        chk("reset_count", int'(on_count), 0);
        @(negedge clk);
        reset = 1'b0;

        // Table: daylight drop latency, hysteresis band, modes.
        for (int i = 0; i < 10; i++) begin
            daylight = vecs[i].dl; threshold = vecs[i].thr;
            presence = vecs[i].pres; mode = vecs[i].md;
            tick();
            chk($sformatf("vec%0d_lights", i), int'(lights), int'(vecs[i].e_lights));
            chk($sformatf("vec%0d_changed", i), int'(changed), int'(vecs[i].e_changed));
            chk($sformatf("vec%0d_dark", i), int'(dark), int'(vecs[i].e_dark));
            chk($sformatf("vec%0d_count", i), int'(on_count), vecs[i].e_count);
        end

        // Hold timer: presence first low at E0 -> lamp off at E0+HOLD.
        mode = '0; daylight = 8'd50; presence = 4'hF;
        tick(); tick(); tick();
        chk("all_on", int'(lights), 15);
        presence = 4'b1110;
        for (int k = 0; k < HOLD; k++) begin
            tick();
            chk($sformatf("hold_e%0d", k), int'(lights[0]), 1);
        end
        tick();
        chk("hold_expire", int'(lights[0]), 0);
        chk("hold_expire_count", int'(on_count), 3);

        // Presence returns mid-hold, then the timer reloads on the next drop.
        presence = 4'hF; tick(); tick();
        presence = 4'b1110; tick(); tick(); tick();
        presence = 4'hF; tick();
        chk("rehigh_on", int'(lights[0]), 1);
        presence = 4'b1110;
        for (int k = 0; k < HOLD; k++) begin
            tick();
            chk($sformatf("reload_e%0d", k), int'(lights[0]), 1);
        end
        tick();
        chk("reload_expire", int'(lights[0]), 0);

        // Async reset mid-hold.
        presence = 4'hF; tick(); tick();
        presence = 4'h0; tick(); tick(); tick();
        chk("pre_reset_hold", int'(lights), 15);
        #3 reset = 1'b1;
        #1;
        chk("rst_hold_lights", int'(lights), 0);
        chk("rst_hold_count", int'(on_count), 0);
        chk("rst_hold_dark", int'(dark), 0);
        @(negedge clk);
        reset = 1'b0; presence = 4'hF; daylight = 8'd200;
        tick(); tick(); tick();
        chk("post_reset_lights", int'(lights), 0);
        chk("post_reset_dark", int'(dark), 0);

        // Async reset mid-force-on.
        mode = 8'hAA; tick();
        chk("force_on_all", int'(lights), 15);
        #3 reset = 1'b1;
        #1;
        chk("rst_force_lights", int'(lights), 0);
        @(negedge clk);
        reset = 1'b0; mode = '0;
        tick(); tick();
        chk("post_force_lights", int'(lights), 0);

        // Saturating bright threshold.
        threshold = 8'd250; presence = '0;
        daylight = 8'd240; tick();
        chk("sat_240", int'(dark), 1);
        daylight = 8'd254; tick();
        chk("sat_254", int'(dark), 1);
        daylight = 8'd255; tick();
        chk("sat_255", int'(dark), 0);

        // Zero threshold: never dark.
        threshold = 8'd0; presence = 4'hF;
        for (int d = 0; d < 256; d += 17) begin
            daylight = 8'(d); tick();
            chk($sformatf("thr0_dark_%0d", d), int'(dark), 0);
        end
        chk("thr0_lights", int'(lights), 0);

        // Randomised run against the reference model.
        do_reset();
        model_reset();
        threshold = 8'd100; presence = '0; mode = '0;
        for (int n = 0; n < 1500; n++) begin
            if (n % 150 == 0) threshold = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                dl = $urandom_range(0, 255);
            end else begin
                dl = int'(threshold) + int'($urandom_range(0, 40)) - 20;
                if (dl < 0) dl = 0;
                if (dl > 255) dl = 255;
            end
            daylight = 8'(dl);
            for (int z = 0; z < ZONES; z++)
                if ($urandom_range(0, 9) < 3) presence[z] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) mode = 8'($urandom);
            else if ($urandom_range(0, 19) == 0) mode = '0;
            model_edge();
            tick();
            chk("rnd_lights", int'(lights), int'(model_lights()));
            chk("rnd_changed", int'(changed), int'(m_changed));
            chk("rnd_dark", int'(dark), int'(m_dark));
            chk("rnd_count", int'(on_count), m_count);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
